data_mem_ctrl: RTL

//  Parametrised successor of the single-cycle data memory. Word-organised RAM

---
 rtl/riscv_pkg.sv | 16 +
 rtl/lsu_lane_align.sv | 61 ++++++
 rtl/data_mem_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store size codes and data-memory controller state encodings.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'd0,
    DMC_WAIT = 2'd1,
    DMC_RESP = 2'd2
  } dmc_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for RV32I loads/stores: store merge into a RAM word and
// load extract with sign/zero extension, plus size/alignment legality.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] merged,
  output logic [31:0] rdata,
  output logic        fmt_err
);

  logic [31:0] lane_data;
  logic [31:0] shifted;

  always_comb begin
    byte_en   = '0;
    lane_data = wdata;
    rdata     = '0;
    fmt_err   = 1'b0;
    shifted   = word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
        rdata     = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: rdata = {24'h0, shifted[7:0]};
      F3_H: begin
        fmt_err   = addr_lo[0];
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
        rdata     = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_HU: begin
        fmt_err = addr_lo[0];
        rdata   = {16'h0, shifted[15:0]};
      end
      F3_W: begin
        fmt_err = |addr_lo;
        byte_en = '1;
        rdata   = shifted;
      end
      default: fmt_err = 1'b1;
    endcase
    // Stores only exist as SB/SH/SW; the unsigned codes are illegal for writes.
    if (write && funct3 > F3_W) fmt_err = 1'b1;
  end

  always_comb begin
    merged = word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data RAM with a valid/ready request port, configurable access
// latency and a one-cycle response pulse carrying load data or a fault flag.
module data_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmc_state_e        state, state_next;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [2:0]        lat_funct3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, enter_resp;
  logic              cur_write;
  logic [2:0]        cur_funct3;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [IDX_W-1:0]  widx;
  logic              in_range, fmt_err, err;
  logic [3:0]        byte_en;
  logic [31:0]       merged, ld_data;

  assign accept     = (state == DMC_IDLE) && req_valid;
  assign enter_resp = (state_next == DMC_RESP) && (state != DMC_RESP);

  // With zero latency RESP is entered on the accepting edge, so the access
  // must be computed from the live inputs rather than the latch.
  assign cur_write  = (state == DMC_IDLE) ? req_write  : lat_write;
  assign cur_funct3 = (state == DMC_IDLE) ? req_funct3 : lat_funct3;
  assign cur_addr   = (state == DMC_IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == DMC_IDLE) ? req_wdata  : lat_wdata;

  assign widx     = cur_addr[IDX_W+1:2];
  assign in_range = (cur_addr[ADDR_W-1:2] >> IDX_W) == '0;
  assign err      = fmt_err || !in_range;

  lsu_lane_align u_align (
    .funct3  (cur_funct3),
    .write   (cur_write),
    .addr_lo (cur_addr[1:0]),
    .word    (mem[widx]),
    .wdata   (cur_wdata),
    .byte_en (byte_en),
    .merged  (merged),
    .rdata   (ld_data),
    .fmt_err (fmt_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DMC_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DMC_IDLE: if (req_valid) state_next = (LATENCY == 0) ? DMC_RESP : DMC_WAIT;
      DMC_WAIT: if (cnt == 4'd1) state_next = DMC_RESP;
      DMC_RESP: state_next = DMC_IDLE;
      default:  state_next = DMC_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == DMC_IDLE);
    resp_valid = (state == DMC_RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (accept) begin
      cnt        <= 4'(LATENCY);
      lat_write  <= req_write;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end else if (state == DMC_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (enter_resp && cur_write && !err) begin
      mem[widx] <= merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_rdata <= (cur_write || err) ? '0 : ld_data;
      resp_err   <= err;
    end else begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

endmodule
